// File: rtl/lbp_host_if.sv
// Bus bundle between the LBP engine side (master) and the host responder (slave).
// Covers the image load stream, gray read port, result write port and dump stream.
interface lbp_host_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 8
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [DATA_W-1:0] gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [DATA_W-1:0] lbp_data;
    logic              finish;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              done;

    modport slave (
        input  ld_valid, ld_data, gray_req, gray_addr,
               lbp_valid, lbp_addr, lbp_data, finish, out_ready,
        output gray_ready, gray_data, out_valid, out_addr, out_data, done
    );

    modport master (
        output ld_valid, ld_data, gray_req, gray_addr,
               lbp_valid, lbp_addr, lbp_data, finish, out_ready,
        input  gray_ready, gray_data, out_valid, out_addr, out_data, done
    );
endinterface

// File: rtl/lbp_host.sv
// Host-side responder for the LBP engine: holds the gray image, serves reads,
// captures result writes and streams the result image out after finish.
module lbp_host #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_PIX  = 16384
) (
    input  logic       clk,
    input  logic       reset,
    lbp_host_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PIX - 1);

    typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DUMP, S_DONE} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] gray_mem [N_PIX];
    logic [DATA_W-1:0] res_mem  [N_PIX];

    logic [ADDR_W-1:0] cnt;
    logic              gray_ready_q;
    logic [DATA_W-1:0] gray_data_q;
    logic              out_valid_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              done_q;

    logic ld_fire_c, lbp_fire_c, rd_fire_c, dump_last_c, issue_c, last_pix_c;

    // Next-state and per-cycle strobes
    always_comb begin
        state_nxt   = state;
        ld_fire_c   = 1'b0;
        lbp_fire_c  = 1'b0;
        rd_fire_c   = 1'b0;
        dump_last_c = 1'b0;
        issue_c     = 1'b0;
        last_pix_c  = (cnt == LAST);
        case (state)
            S_LOAD: begin
                ld_fire_c = bus.ld_valid;
                if (bus.ld_valid && last_pix_c) state_nxt = S_SERVE;
            end
            S_SERVE: begin
                lbp_fire_c = bus.lbp_valid;
                rd_fire_c  = bus.gray_req;
                if (bus.finish) state_nxt = S_DUMP;
            end
            S_DUMP: begin
                // A beat is fetched whenever the output slot is empty or drains this cycle
                dump_last_c = out_valid_q && (out_addr_q == LAST);
                issue_c     = !dump_last_c && (!out_valid_q || bus.out_ready);
                if (dump_last_c && bus.out_ready) state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_LOAD;
        else       state <= state_nxt;
    end

    // Memory write ports; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (ld_fire_c) begin
            gray_mem[cnt] <= bus.ld_data;
            res_mem[cnt]  <= '0;
        end else if (lbp_fire_c) begin
            res_mem[bus.lbp_addr] <= bus.lbp_data;
        end
    end

    // Counter, read port and dump stream registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            gray_ready_q <= 1'b0;
            gray_data_q  <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            gray_ready_q <= (state_nxt == S_SERVE);
            done_q       <= (state_nxt == S_DONE);
            if (ld_fire_c) cnt <= last_pix_c ? '0 : cnt + ADDR_W'(1);
            if (rd_fire_c) gray_data_q <= gray_mem[bus.gray_addr];
            if (issue_c) begin
                out_valid_q <= 1'b1;
                out_addr_q  <= cnt;
                out_data_q  <= res_mem[cnt];
                cnt         <= cnt + ADDR_W'(1);
            end else if (state_nxt == S_DONE) begin
                out_valid_q <= 1'b0;
                out_addr_q  <= '0;
                out_data_q  <= '0;
            end
        end
    end

    assign bus.gray_ready = gray_ready_q;
    assign bus.gray_data  = gray_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_data   = out_data_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_lbp_host.sv
// Directed bench for lbp_host: load, gray reads, result writes, dump with
// backpressure, and reset in the middle of a dump.
module tb_lbp_host;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned N_PIX  = 16384;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    lbp_host_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lbp_host #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_PIX(N_PIX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected result memory: 0x55 at 7 and 0x11 at 16383 only after the engine writes
    function automatic logic [7:0] exp_res(input int a, input bit written);
        if (!written) return 8'h00;
        if (a == 7) return 8'h55;
        if (a == 16383) return 8'h11;
        return 8'h00;
    endfunction

    task automatic load_pixels(input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps && (i % 997 == 5)) begin
                bus.ld_valid = 1'b0;
                step();
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'(i);
            step();
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic pulse_finish();
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
    endtask

    task automatic test_reset();
        bus.ld_valid = 0; bus.ld_data = 0; bus.gray_req = 0; bus.gray_addr = 0;
        bus.lbp_valid = 0; bus.lbp_addr = 0; bus.lbp_data = 0; bus.finish = 0;
        bus.out_ready = 0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        n_cmp++;
        if (bus.gray_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: gray_ready=%b out_valid=%b done=%b, required 0/0/0",
                     bus.gray_ready, bus.out_valid, bus.done);
        end
        n_cmp++;
        if (bus.gray_data !== 8'h00 || bus.out_addr !== 14'h0 || bus.out_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: gray_data=%h out_addr=%h out_data=%h, required 0/0/0",
                     bus.gray_data, bus.out_addr, bus.out_data);
        end
    endtask

    task automatic test_load();
        load_pixels(0, int'(N_PIX) - 2, 1'b1);
        n_cmp++;
        if (bus.gray_ready !== 1'b0) begin
            n_err++;
            $display("FAIL load_not_ready: gray_ready=%b, required 0", bus.gray_ready);
        end
        load_pixels(int'(N_PIX) - 1, int'(N_PIX) - 1, 1'b0);
        n_cmp++;
        if (bus.gray_ready !== 1'b1) begin
            n_err++;
            $display("FAIL load_ready: gray_ready=%b, required 1", bus.gray_ready);
        end
        bus.gray_req = 1'b1; bus.gray_addr = 14'h1234;
        step();
        bus.gray_req = 1'b0;
        n_cmp++;
        if (bus.gray_data !== 8'h34) begin
            n_err++;
            $display("FAIL read_1234: gray_data=%h, required 34", bus.gray_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        logic [13:0] adr [3];
        exp = '{8'h05, 8'h06, 8'hFF};
        adr = '{14'd5, 14'd6, 14'd16383};
        bus.gray_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.gray_addr = adr[i];
            step();
            n_cmp++;
            if (bus.gray_data !== exp[i]) begin
                n_err++;
                $display("FAIL b2b_read%0d: gray_data=%h, required %h", i, bus.gray_data, exp[i]);
            end
        end
        bus.gray_req = 1'b0; bus.gray_addr = 14'd5;
        step(); step();
        n_cmp++;
        if (bus.gray_data !== 8'hFF) begin
            n_err++;
            $display("FAIL read_hold: gray_data=%h, required ff", bus.gray_data);
        end
        // ld_valid while serving must not touch GRAY[0]
        bus.ld_valid = 1'b1; bus.ld_data = 8'h77;
        step();
        bus.ld_valid = 1'b0;
        bus.gray_req = 1'b1; bus.gray_addr = 14'd0;
        step();
        bus.gray_req = 1'b0;
        n_cmp++;
        if (bus.gray_data !== 8'h00) begin
            n_err++;
            $display("FAIL ld_ignored: gray_data=%h, required 00", bus.gray_data);
        end
    endtask

    task automatic test_lbp_write();
        bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd7; bus.lbp_data = 8'hAA;
        step();
        bus.lbp_data = 8'h55;
        step();
        // Final write, read and finish all on the same edge
        bus.lbp_addr = 14'd16383; bus.lbp_data = 8'h11;
        bus.gray_req = 1'b1; bus.gray_addr = 14'd2;
        pulse_finish();
        bus.gray_req = 1'b0;
        bus.lbp_valid = 1'b0;
        n_cmp++;
        if (bus.gray_data !== 8'h02 || bus.gray_ready !== 1'b0) begin
            n_err++;
            $display("FAIL finish_edge: gray_data=%h gray_ready=%b, required 02/0",
                     bus.gray_data, bus.gray_ready);
        end
    endtask

    // Accept beats until max_beats; optional 1,0,0,1 ready pattern for the first cycles
    task automatic run_dump(input int max_beats, input bit toggle, input bit written, input bit full);
        int beats, cyc, wait_cyc, exp_addr;
        logic pv, pr;
        logic [13:0] pa;
        logic [7:0] pd;
        logic [3:0] pat;
        pat = 4'b1001;
        beats = 0; cyc = 0; exp_addr = 0; wait_cyc = 0;
        bus.out_ready = 1'b0;
        // Result write after finish must be ignored
        bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd8; bus.lbp_data = 8'h99;
        while (!bus.out_valid && wait_cyc < 2) begin
            step();
            bus.lbp_valid = 1'b0;
            wait_cyc++;
        end
        bus.lbp_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL dump_latency: out_valid=%b after %0d cycles, required 1", bus.out_valid, wait_cyc);
            return;
        end
        while (beats < max_beats && cyc < 40000) begin
            bus.out_ready = (toggle && cyc < 8) ? pat[3 - (cyc % 4)] : 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (bus.out_addr !== 14'(exp_addr) || bus.out_data !== exp_res(exp_addr, written)) begin
                    n_err++;
                    $display("FAIL dump_beat: addr=%0d data=%h, required addr=%0d data=%h",
                             bus.out_addr, bus.out_data, exp_addr, exp_res(exp_addr, written));
                end
                beats++;
                exp_addr++;
            end else if (cyc >= 8 && beats > 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dump_bubble: out_valid=%b at beat %0d, required 1", bus.out_valid, beats);
            end
            pv = bus.out_valid; pr = bus.out_ready; pa = bus.out_addr; pd = bus.out_data;
            step();
            cyc++;
            if (pv && !pr) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.out_addr !== pa || bus.out_data !== pd) begin
                    n_err++;
                    $display("FAIL dump_stall: valid=%b addr=%0d data=%h, required 1/%0d/%h",
                             bus.out_valid, bus.out_addr, bus.out_data, pa, pd);
                end
            end
        end
        n_cmp++;
        if (beats != max_beats) begin
            n_err++;
            $display("FAIL dump_count: beats=%0d, required %0d", beats, max_beats);
        end
        if (full) begin
            step(); step();
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.done !== 1'b1) begin
                n_err++;
                $display("FAIL dump_done: out_valid=%b done=%b, required 0/1", bus.out_valid, bus.done);
            end
        end
    endtask

    task automatic test_dump();
        run_dump(int'(N_PIX), 1'b1, 1'b1, 1'b1);
        // finish in DONE is ignored
        pulse_finish();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.gray_ready !== 1'b0) begin
            n_err++;
            $display("FAIL done_hold: done=%b out_valid=%b gray_ready=%b, required 1/0/0",
                     bus.done, bus.out_valid, bus.gray_ready);
        end
    endtask

    task automatic test_reset_mid_dump();
        reset = 1'b1; step(); reset = 1'b0;
        load_pixels(0, int'(N_PIX) - 1, 1'b0);
        pulse_finish();
        run_dump(100, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_addr !== 14'h0 || bus.out_data !== 8'h00 ||
            bus.done !== 1'b0 || bus.gray_ready !== 1'b0 || bus.gray_data !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset: valid=%b addr=%0d data=%h done=%b ready=%b gdata=%h, required all 0",
                     bus.out_valid, bus.out_addr, bus.out_data, bus.done, bus.gray_ready, bus.gray_data);
        end
        bus.out_ready = 1'b0;
        step();
        reset = 1'b0;
        bus.gray_req = 1'b1; bus.gray_addr = 14'h1234;
        step();
        bus.gray_req = 1'b0;
        pulse_finish();
        step();
        n_cmp++;
        if (bus.gray_data !== 8'h00 || bus.gray_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL early_req: gray_data=%h gray_ready=%b out_valid=%b, required 00/0/0",
                     bus.gray_data, bus.gray_ready, bus.out_valid);
        end
        load_pixels(0, int'(N_PIX) - 1, 1'b0);
        pulse_finish();
        run_dump(5, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_load();
        test_back_to_back();
        test_lbp_write();
        test_dump();
        test_reset_mid_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lbp_host.md
# lbp_host

Host-side responder for the LBP engine's gray-image / LBP-result interface. It holds the 128x128 gray image and serves the engine's `gray_req`/`gray_addr` reads with `gray_data`. It captures every `lbp_valid` write into a result memory. After `finish`, it streams the result image out on a valid/ready port. It sits opposite the LBP engine in the chip-level and FPGA harness, replacing the behavioural memories used in simulation.

## Interface
Parameters:
- `ADDR_W`, 14, pixel address width
- `DATA_W`, 8, pixel / LBP code width
- `N_PIX`, 16384, image size; the last address is `N_PIX-1`

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high
- `ld_valid` in 1: load-stream pixel strobe
- `ld_data` in DATA_W: gray pixel, raster order from address 0
- `gray_ready` out 1: image loaded, engine may request
- `gray_req` in 1: engine read request
- `gray_addr` in ADDR_W: engine read address
- `gray_data` out DATA_W: read data
- `lbp_valid` in 1: engine result write strobe
- `lbp_addr` in ADDR_W: result address
- `lbp_data` in DATA_W: LBP code
- `finish` in 1: engine done
- `out_valid` out 1: dump beat valid
- `out_ready` in 1: dump sink accepts
- `out_addr` out ADDR_W: dump beat address
- `out_data` out DATA_W: dump beat data
- `done` out 1: dump complete

## Operation
- Two single-port-per-side memories, N_PIX x DATA_W each: GRAY and RES.
- FSM states and transitions:
  - LOAD → SERVE when the `N_PIX`-th pixel is written.
  - SERVE → DUMP on `finish`.
  - DUMP → DONE when the beat for address `N_PIX-1` is accepted.
  - DONE holds until reset.
- LOAD:
  - Each `ld_valid` writes `ld_data` to GRAY[cnt] and 0 to RES[cnt], then increments `cnt`.
  - After the write at `cnt = N_PIX-1`, `cnt` wraps to 0 and the FSM enters SERVE.
- SERVE:
  - `gray_ready` = 1.
  - `gray_req` = 1 reads GRAY[`gray_addr`].
  - `lbp_valid` = 1 writes `lbp_data` to RES[`lbp_addr`]. The last write to an address wins.
- DUMP:
  - Emits RES[0] through RES[`N_PIX-1`] in address order, one beat per `out_valid && out_ready`.
  - `out_addr` equals the address of the data on `out_data`.
- DONE: `done` = 1, all other outputs idle.

## Timing
- Reset values:
  - State LOAD, `cnt` 0.
  - `gray_ready`, `gray_data`, `out_valid`, `out_addr`, `out_data`, `done` all 0.
  - Memory contents are not reset.
- `gray_data` is registered. A request sampled at edge k makes data valid after edge k and holds it until the next accepted request.
- A request with `gray_ready` = 0 is ignored and `gray_data` holds.
- `gray_ready` rises on the edge that writes the last LOAD pixel. It falls on the edge that samples `finish` = 1 in SERVE.
- A `gray_req` sampled together with `finish` is still served.
- `lbp_valid` is written at the sampling edge. A write coincident with `finish` is kept.
- `lbp_valid` outside SERVE is ignored.
- `finish` in LOAD, DUMP or DONE is ignored.
- `ld_valid` outside LOAD is ignored.
- Dump latency: first `out_valid` = 1 no later than 2 cycles after `finish` is sampled.
- Dump backpressure: while `out_valid && !out_ready`, `out_addr` and `out_data` hold stable.
- Dump throughput: with `out_ready` held at 1, one beat per cycle and no bubbles after the first beat.
- `out_valid` drops on the edge accepting the last beat. `done` rises on the same edge and stays 1 until reset.
- Reset mid-operation (any state) aborts immediately to LOAD with `cnt` = 0. The image must be reloaded.

## Test plan
- Load ramp GRAY[i] = i[7:0] with gaps in `ld_valid`: `gray_ready` = 0 until the 16384th strobe, then 1 on that edge. `gray_req` with `gray_addr` = 0x1234 yields `gray_data` = 0x34 the next cycle.
- Back-to-back `gray_req` at addresses 5, 6, 16383 on consecutive cycles: `gray_data` = 0x05, 0x06, 0xFF on successive cycles. With `gray_req` = 0, `gray_data` holds 0xFF.
- Write `lbp_data` = 0xAA at address 7, then 0x55 at address 7. Write 0x11 at address 16383 in the same cycle that `finish` is asserted. Dump shows addr 7 = 0x55 and addr 16383 = 0x11; all other addresses are 0.
- Dump with `out_ready` toggling 1,0,0,1: the beat for addr 0 is accepted once. Addr 1 is held stable across the stalls. The total is exactly 16384 accepted beats, then `done` = 1 and `out_valid` = 0.
- Assert `reset` mid-DUMP at beat 100: all outputs 0 and state LOAD. After reload and a new `finish`, the dump restarts at addr 0. A `gray_req` issued before reload completes leaves `gray_data` at 0.
